// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM encoding, default word width
// and the bit-counter width helper.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DWIDTH_DEFAULT = 8;

    // Counter must hold 0..DWIDTH inclusive
    function automatic int cnt_width(input int dwidth);
        return $clog2(dwidth + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with a history flop that
// produces single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    // Reset to the pin's idle level so release does not fake an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{INIT}};
            hist_q <= INIT;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~hist_q;
    assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI responder: oversampled sclk/cs_n/mosi, one-word transmit holding
// buffer and one-word receive buffer with underrun/overrun pulses.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_rd,
    output logic              underrun,
    output logic              overrun
);

    localparam int            CW       = cnt_width(DWIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DWIDTH);

    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DWIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DWIDTH-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DWIDTH-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic              cs_pend_q, cs_pend_d;
    logic              uflow_pend_q, uflow_pend_d;
    logic              load_word;

    // Reset asserts asynchronously, releases two clk edges later
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        underrun_d   = 1'b0;
        overrun_d    = 1'b0;
        cs_pend_d    = cs_pend_q;
        uflow_pend_d = uflow_pend_q;
        load_word    = 1'b0;

        if (rx_rd) rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    cs_pend_d = 1'b0;
                end else if ((cs_fall || cs_pend_q) && !cs_s) begin
                    // A select that arrives with sclk high waits for sclk low
                    if (sclk_s) begin
                        cs_pend_d = 1'b1;
                    end else begin
                        cs_pend_d = 1'b0;
                        state_d   = SHIFT;
                        miso_oe_d = 1'b1;
                        load_word = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d      = IDLE;
                    miso_oe_d    = 1'b0;
                    miso_d       = 1'b0;
                    cnt_d        = '0;
                    uflow_pend_d = 1'b0;
                end else if (sclk_rise && cnt_q != CNT_FULL) begin
                    rx_shift_d = {rx_shift_q[DWIDTH-2:0], mosi_s};
                    cnt_d      = cnt_q + 1'b1;
                    if (uflow_pend_q) begin
                        underrun_d   = 1'b1;
                        uflow_pend_d = 1'b0;
                    end
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q & ~rx_rd;
                    end
                end else if (sclk_fall) begin
                    if (cnt_q == CNT_FULL) begin
                        load_word = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DWIDTH-2:0], 1'b0};
                        miso_d     = tx_shift_q[DWIDTH-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reload at a word boundary only reports underrun once the next
        // word actually begins, so the last fall of a frame is not penalised
        if (load_word) begin
            cnt_d       = '0;
            hold_full_d = 1'b0;
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d = '0;
                if (state_q == IDLE) underrun_d   = 1'b1;
                else                 uflow_pend_d = 1'b1;
            end
            miso_d = tx_shift_d[DWIDTH-1];
        end

        if (tx_wr) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            cs_pend_q    <= 1'b0;
            uflow_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            cs_pend_q    <= cs_pend_d;
            uflow_pend_q <= uflow_pend_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as the SPI initiator at clk/8 and
// checks received words, miso bit streams and the status pulses.
`timescale 1ns/1ps
module tb_spi_peripheral;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd;
    logic       underrun;
    logic       overrun;

    int checkCount;
    int errorCount;
    int underrunCount;
    int overrunCount;

    logic [7:0] misoWord;
    logic [7:0] misoWord2;

    spi_peripheral #(.DWIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_rd(rx_rd), .underrun(underrun), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses are registered on the rising edge, so count them on the falling one
    always @(negedge clk) begin
        if (underrun) underrunCount++;
        if (overrun)  overrunCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeTx(input logic [7:0] word);
        tx_data = word;
        tx_wr   = 1'b1;
        waitClocks(1);
        tx_wr   = 1'b0;
    endtask

    task automatic readRx();
        rx_rd = 1'b1;
        waitClocks(1);
        rx_rd = 1'b0;
    endtask

    // Sends nbits of word MSB first, sampling miso just before each rising sclk
    task automatic applyStimulus(input logic [7:0] word, input int nbits,
                                 input bit endFrame, output logic [7:0] misoOut);
        misoOut = '0;
        cs_n    = 1'b0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = word[i];
            waitClocks(4);
            if (i == 7) checkOutput("miso_oe_active", 32'(miso_oe), 1);
            misoOut[i] = miso;
            sclk = 1'b1;
            waitClocks(4);
            sclk = 1'b0;
        end
        waitClocks(4);
        if (endFrame) begin
            cs_n = 1'b1;
            mosi = 1'b0;
            waitClocks(6);
        end
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        underrunCount = 0;
        overrunCount  = 0;
        rst     = 1'b0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = '0;
        tx_wr   = 1'b0;
        rx_rd   = 1'b0;

        waitClocks(3);
        checkOutput("reset_miso", 32'(miso), 0);
        checkOutput("reset_miso_oe", 32'(miso_oe), 0);
        checkOutput("reset_tx_ready", 32'(tx_ready), 1);
        checkOutput("reset_rx_data", 32'(rx_data), 0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 0);
        checkOutput("reset_pulses", 32'({underrun, overrun}), 0);
        rst = 1'b1;
        waitClocks(6);

        $display("[TB] single frame");
        writeTx(8'hA5);
        checkOutput("tx_ready_loaded", 32'(tx_ready), 0);
        applyStimulus(8'h3C, 8, 1'b1, misoWord);
        checkOutput("f1_miso", 32'(misoWord), 'hA5);
        checkOutput("f1_rx_data", 32'(rx_data), 'h3C);
        checkOutput("f1_rx_valid", 32'(rx_valid), 1);
        checkOutput("f1_tx_ready", 32'(tx_ready), 1);
        checkOutput("f1_miso_oe_off", 32'(miso_oe), 0);
        readRx();
        checkOutput("f1_rx_consumed", 32'(rx_valid), 0);

        $display("[TB] back-to-back words");
        writeTx(8'h81);
        fork
            applyStimulus(8'h11, 8, 1'b0, misoWord);
            begin
                waitClocks(10);
                writeTx(8'h7E);
            end
        join
        checkOutput("b2b_miso_w1", 32'(misoWord), 'h81);
        checkOutput("b2b_rx_w1", 32'(rx_data), 'h11);
        readRx();
        applyStimulus(8'h22, 8, 1'b1, misoWord2);
        checkOutput("b2b_miso_w2", 32'(misoWord2), 'h7E);
        checkOutput("b2b_rx_w2", 32'(rx_data), 'h22);
        checkOutput("b2b_rx_valid", 32'(rx_valid), 1);
        checkOutput("b2b_overrun", 32'(overrunCount), 0);
        checkOutput("b2b_underrun", 32'(underrunCount), 0);
        readRx();

        $display("[TB] underrun frame");
        applyStimulus(8'h55, 8, 1'b1, misoWord);
        checkOutput("ur_miso_zero", 32'(misoWord), 0);
        checkOutput("ur_count", 32'(underrunCount), 1);
        checkOutput("ur_rx_data", 32'(rx_data), 'h55);

        $display("[TB] overrun frame");
        writeTx(8'h12);
        applyStimulus(8'h66, 8, 1'b1, misoWord);
        checkOutput("or_miso", 32'(misoWord), 'h12);
        checkOutput("or_count", 32'(overrunCount), 1);
        checkOutput("or_rx_data", 32'(rx_data), 'h66);
        checkOutput("or_rx_valid", 32'(rx_valid), 1);
        readRx();

        $display("[TB] aborted frame");
        writeTx(8'hF0);
        applyStimulus(8'hFF, 5, 1'b1, misoWord);
        checkOutput("abort_miso_oe", 32'(miso_oe), 0);
        checkOutput("abort_miso", 32'(miso), 0);
        checkOutput("abort_rx_valid", 32'(rx_valid), 0);
        checkOutput("abort_rx_data", 32'(rx_data), 'h66);
        writeTx(8'h3A);
        applyStimulus(8'hC3, 8, 1'b1, misoWord);
        checkOutput("abort_next_rx", 32'(rx_data), 'hC3);
        checkOutput("abort_next_miso", 32'(misoWord), 'h3A);
        checkOutput("abort_next_valid", 32'(rx_valid), 1);

        $display("[TB] reset mid-frame");
        writeTx(8'h99);
        applyStimulus(8'hFF, 3, 1'b0, misoWord);
        checkOutput("pre_rst_miso", 32'(miso), 1);
        rst = 1'b0;
        #1;
        checkOutput("rst_miso_oe", 32'(miso_oe), 0);
        checkOutput("rst_miso", 32'(miso), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 0);
        checkOutput("rst_rx_data", 32'(rx_data), 0);
        checkOutput("rst_tx_ready", 32'(tx_ready), 1);
        cs_n = 1'b1;
        mosi = 1'b0;
        waitClocks(3);
        rst = 1'b1;
        waitClocks(6);
        writeTx(8'hE7);
        applyStimulus(8'h5A, 8, 1'b1, misoWord);
        checkOutput("post_rst_rx", 32'(rx_data), 'h5A);
        checkOutput("post_rst_miso", 32'(misoWord), 'hE7);
        checkOutput("post_rst_valid", 32'(rx_valid), 1);
        checkOutput("final_underrun", 32'(underrunCount), 1);
        checkOutput("final_overrun", 32'(overrunCount), 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
